// File: rtl/ysyx_23060061_mem_arbiter.sv
// rtl/ysyx_23060061_mem_arbiter.sv - two-master round-robin arbiter for a single memory port
module ysyx_23060061_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_wen,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic            m0_resp_valid,
    input  logic            m0_resp_ready,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_wen,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_resp_valid,
    input  logic            m1_resp_ready,
    output logic [DW-1:0]   m1_rdata,

    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic [AW-1:0]   s_addr,
    output logic            s_wen,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wmask,
    input  logic            s_resp_valid,
    output logic            s_resp_ready,
    input  logic [DW-1:0]   s_rdata,

    output logic            grant,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            s_req_valid_q, s_req_valid_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic            s_wen_q, s_wen_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [DW/8-1:0] s_wmask_q, s_wmask_d;

    logic any_req;
    logic win;
    logic is_idle;
    logic in_resp;
    logic own_resp_ready;

    // On a tie the master that did not own the last completed transaction wins.
    assign any_req        = m0_req_valid | m1_req_valid;
    assign win            = (m0_req_valid & m1_req_valid) ? ~last_q : m1_req_valid;
    assign is_idle        = (state_q == IDLE);
    assign in_resp        = (state_q == RESP);
    assign own_resp_ready = grant_q ? m1_resp_ready : m0_resp_ready;

    assign m0_req_ready  = is_idle & m0_req_valid & ~win;
    assign m1_req_ready  = is_idle & m1_req_valid & win;
    assign m0_resp_valid = in_resp & ~grant_q & s_resp_valid;
    assign m1_resp_valid = in_resp & grant_q & s_resp_valid;
    assign s_resp_ready  = in_resp & own_resp_ready;
    assign m0_rdata      = s_rdata;
    assign m1_rdata      = s_rdata;

    assign s_req_valid = s_req_valid_q;
    assign s_addr      = s_addr_q;
    assign s_wen       = s_wen_q;
    assign s_wdata     = s_wdata_q;
    assign s_wmask     = s_wmask_q;
    assign grant       = grant_q;
    assign busy        = busy_q;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        busy_d        = busy_q;
        s_req_valid_d = s_req_valid_q;
        s_addr_d      = s_addr_q;
        s_wen_d       = s_wen_q;
        s_wdata_d     = s_wdata_q;
        s_wmask_d     = s_wmask_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = REQ;
                    grant_d       = win;
                    busy_d        = 1'b1;
                    s_req_valid_d = 1'b1;
                    s_addr_d      = win ? m1_addr  : m0_addr;
                    s_wen_d       = win ? m1_wen   : m0_wen;
                    s_wdata_d     = win ? m1_wdata : m0_wdata;
                    s_wmask_d     = win ? m1_wmask : m0_wmask;
                end
            end
            REQ: begin
                if (s_req_ready) begin
                    state_d       = RESP;
                    s_req_valid_d = 1'b0;
                end
            end
            RESP: begin
                // Round-robin pointer moves only when the response is consumed.
                if (s_resp_valid && own_resp_ready) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                busy_d        = 1'b0;
                s_req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            grant_q       <= 1'b0;
            busy_q        <= 1'b0;
            s_req_valid_q <= 1'b0;
            s_addr_q      <= '0;
            s_wen_q       <= 1'b0;
            s_wdata_q     <= '0;
            s_wmask_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            s_req_valid_q <= s_req_valid_d;
            s_addr_q      <= s_addr_d;
            s_wen_q       <= s_wen_d;
            s_wdata_q     <= s_wdata_d;
            s_wmask_q     <= s_wmask_d;
        end
    end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
# ysyx_23060061_mem_arbiter

Two-master, one-slave memory arbiter that shares the single memory port between instruction fetch (master 0, IFU) and load/store (master 1, LSU) once the core moves off the single-cycle DPI memory model. Each master issues one request at a time over a valid/ready request channel and receives read data on a valid/ready response channel. The arbiter grants round-robin, holds one outstanding transaction, registers the winning request and forwards it to the slave. It routes the slave response back to the owning master.

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8); mask width DW/8

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- mN_req_valid  in  1  master N request valid (N = 0, 1)
- mN_req_ready  out  1  master N request accepted this cycle
- mN_addr  in  AW  request address
- mN_wen  in  1  1 = write, 0 = read
- mN_wdata  in  DW  write data
- mN_wmask  in  DW/8  byte write mask
- mN_resp_valid  out  1  response valid to master N
- mN_resp_ready  in  1  master N accepts response
- mN_rdata  out  DW  read data (s_rdata, valid only with mN_resp_valid)
- s_req_valid  out  1  request valid to slave
- s_req_ready  in  1  slave accepts request
- s_addr / s_wen / s_wdata / s_wmask  out  AW/1/DW/DW/8  registered request fields
- s_resp_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter accepts response
- s_rdata  in  DW  slave read data (writes also return one response)
- grant  out  1  current owner (0 = IFU, 1 = LSU)
- busy  out  1  state != IDLE

## Operation
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - The arbiter picks a winner among asserted mN_req_valid.
  - With one requester, that requester wins. With both, the winner is the master that is not `last`.
  - mW_req_ready=1 combinationally for the winner only.
  - On that cycle the arbiter latches the winner's addr/wen/wdata/wmask into s_* registers, sets grant=W, and goes to REQ.
- REQ:
  - s_req_valid=1. s_* fields are held stable.
  - Both mN_req_ready=0.
  - On s_req_ready=1, go to RESP.
- RESP:
  - m[grant]_resp_valid = s_resp_valid. s_resp_ready = m[grant]_resp_ready.
  - The other master's resp_valid=0.
  - On s_resp_valid & s_resp_ready, the arbiter sets last=grant and returns to IDLE.
- Outside RESP, all resp_valid=0 and s_resp_ready=0.
- mN_rdata is driven from s_rdata to both masters at all times. Only resp_valid qualifies it.
- A master that drops req_valid before being granted loses nothing. The arbiter does not latch ungranted requests.
- The arbiter never drops a granted transaction. It never issues a second s_req_valid before the response handshake.

## Timing
- Reset (rst=0, asynchronous) puts the block in this state:
  - State: IDLE.
  - Registered outputs: grant=0, busy=0, s_req_valid=0, s_addr=0, s_wen=0, s_wdata=0, s_wmask=0.
  - Round-robin pointer: last=1, so IFU wins the first tie.
  - Combinational outputs with FSM in IDLE: all mN_req_ready=1 only if the corresponding valid wins; all resp_valid=0; s_resp_ready=0.
- Reset asserted mid-transaction aborts to IDLE immediately. No response is delivered for the aborted request.
- Request accept is the IDLE cycle with mW_req_valid & mW_req_ready. s_req_valid rises the next cycle.
- Minimum transaction is 3 cycles: accept (IDLE), slave accept (REQ, s_req_ready already high), response (RESP, s_resp_valid & ready already high).
- After the RESP handshake, IDLE can grant again on the very next cycle, so back-to-back throughput is one transaction per 3 cycles minimum.
- Simultaneous s_req_ready in REQ and s_resp_valid: the response is ignored in REQ and taken in RESP. The slave must hold s_resp_valid until s_resp_ready.
- The pointer updates only on response completion. A master that keeps its request asserted across a transaction gets the next grant if the other master requests.

## Test plan
- Reset → after release: grant=0, busy=0, s_req_valid=0, m0/m1_req_ready=0 with both valids low. Assert rst=0 while in REQ → busy=0 and s_req_valid=0 without a clock edge.
- IFU only requests read addr 0x80000000, slave ready=1, s_rdata=0x00100093 the following cycle → m0_req_ready pulse at cycle 0; s_req_valid/s_addr=0x80000000 at cycle 1; m0_resp_valid with rdata 0x00100093 at cycle 2; m1_resp_valid stays 0.
- Both request from reset (m0 addr 0x80000004, m1 write addr 0x80001000 wdata 0xDEADBEEF wmask 0xF), held until accepted → IFU granted first; LSU granted in the IDLE cycle right after IFU's response; s_wen=1, s_wdata=0xDEADBEEF, s_wmask=0xF on second transaction.
- Both hold requests continuously for 6 transactions → grant alternates 0,1,0,1,0,1.
- Slave stalls s_req_ready 4 cycles, then s_resp_valid 3 cycles, and master stalls resp_ready 2 cycles → s_addr/s_wdata stable throughout REQ; busy=1 throughout; exactly one m resp handshake; no new grant until it completes.
- LSU request valid for 1 cycle while IFU transaction in REQ, then dropped → LSU never granted; no s_req_valid issued for it.
